period_meter: RTL and testbench
===============================

Name: period_meter

Overview:
- Measures a slow periodic signal in fast-clock cycles, e.g. the output of the team's clock divider or an external slow clock.
- Reports two values, each as a count of clk_in cycles:
  - full period (rising edge to rising edge);
  - high time (rising edge to falling edge).
- Sits beside the divider in the CPU test harness to check divide ratios on-chip.
- Results go to the core through a start / valid / ack handshake.

Parameters:
- CNT_W, 16: width of the cycle counter and both result fields.
- SYNC_STAGES, 2: number of flip-flop synchronizer stages on sig_in; legal range 2 to 4.

Ports:
- clk_in  input  1  Sole clock. All logic is on the rising edge.
- reset  input  1  Asynchronous, active-low reset. Assertion (low) clears all state immediately. Deassertion takes effect on clk_in.
- sig_in  input  1  Slow signal to measure. It is asynchronous to clk_in.
- start  input  1  Single-cycle pulse that requests one measurement.
- ack  input  1  Consumer accepts the current result.
- busy  output  1  High while a measurement is in progress.
- valid  output  1  Result fields are valid. Held high until ack or start.
- period  output  CNT_W  Rising-to-rising cycle count.
- high_time  output  CNT_W  Rising-to-falling cycle count.
- overflow  output  1  Counter saturated before the closing edge arrived.

Behaviour:
- Reset values: busy=0, valid=0, period=0, high_time=0, overflow=0, state=IDLE, cnt=0. The synchronizer chain is also cleared to 0.
- Input path:
  - sig_in passes through SYNC_STAGES flops to give sig_s; sig_d is sig_s delayed by 1 cycle.
  - rise = sig_s & ~sig_d; fall = ~sig_s & sig_d.
  - Input-to-edge latency is constant. It therefore cancels out of every reported difference.
- States:
  - IDLE:
    - start=1 moves to ARM: set busy=1, clear valid and overflow.
    - start while valid=1 is legal. It discards the old result.
  - ARM:
    - Wait for rise. On the rise cycle (t0): cnt<=1, go to MEAS_HIGH.
    - A level already high at start is not treated as an edge. The block waits for the next real rise.
  - MEAS_HIGH:
    - On fall: high_time<=cnt, cnt<=cnt+1, go to MEAS_LOW.
    - Otherwise cnt increments.
  - MEAS_LOW:
    - On rise: period<=cnt, go to DONE.
    - Otherwise cnt increments.
  - DONE (1 cycle): valid<=1, busy<=0, go to IDLE.
- Counting rule: at cycle t0+k, cnt equals k. So period = t1 - t0 and high_time = tf - t0, where t1 is the closing rise and tf is the fall.
- Latency: valid rises 2 clk_in cycles after the closing rise is detected (one cycle to capture, one cycle in DONE).
- Saturation:
  - If cnt = 2^CNT_W - 1 and the closing edge is not present, set overflow=1 and period=all-ones.
  - high_time=all-ones if the measurement was still in MEAS_HIGH, otherwise it keeps the captured value.
  - Then go to DONE. The counter never wraps.
- Handshake:
  - ack with valid=1 clears valid on the next cycle. Result fields hold their values until the next start.
  - ack with valid=0 is ignored.
  - start while busy=1 is ignored.
  - start and ack in the same cycle: start takes priority (valid cleared, measurement begins).
- Reset mid-measurement aborts immediately: all outputs return to their reset values, and no partial result is reported.
- Minimum measurable pulse: a 1-cycle high on sig_s gives high_time=1. A pulse shorter than one clk_in cycle may be missed; this is accepted behaviour.

Decomposition:
- Shared package holds:
  - state enum {IDLE, ARM, MEAS_HIGH, MEAS_LOW, DONE};
  - CNT_MAX derived from CNT_W;
  - default parameter constants.
- One natural sub-module, edge_sync:
  - contents: SYNC_STAGES synchronizer plus the edge detector;
  - outputs: rise and fall;
  - reuse: shared with other asynchronous inputs in the harness.

Test Plan:
- sig_in square wave, 3 cycles high / 3 low; start at cycle 2 -> valid with period=6, high_time=3, overflow=0. valid held until ack, then low one cycle after ack.
- sig_in driven by the divider with a 6-cycle period, duty 50% -> period=6, high_time=3. Repeat 4 back-to-back start/ack rounds; each round gives the same values.
- CNT_W=4, sig_in held high forever after one rise -> overflow=1, period=15, high_time=15, busy=0 after DONE.
- sig_in high at the time of start (8 high / 2 low wave) -> the first level is ignored. The measurement is rising-to-rising: period=10, high_time=8.
- reset driven low during MEAS_LOW, then released -> busy=0, valid=0, period=0 immediately. No valid appears until a new start.
- start and ack pulsed together while valid=1 -> valid=0 and busy=1 on the next cycle. Extra start pulses while busy=1 do not restart the count; the result matches a single measurement.

Source files
------------

// File: rtl/period_meter_pkg.sv
// Shared types and defaults for the period meter and its input synchronizer.
package period_meter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        MEAS_HIGH,
        MEAS_LOW,
        DONE
    } state_e;

    localparam int unsigned DEF_CNT_W       = 16;
    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned MIN_SYNC_STAGES = 2;
    localparam int unsigned MAX_SYNC_STAGES = 4;

    // Saturation value of the default-width counter; instances derive theirs from CNT_W.
    localparam logic [DEF_CNT_W-1:0] DEF_CNT_MAX = '1;

endpackage

// File: rtl/period_meter_edge_sync.sv
// Multi-flop synchronizer for an asynchronous level, followed by a
// single-cycle rise/fall detector on the synchronized value.
module edge_sync
    import period_meter_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic sig_in,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   sig_d_q;
    logic                   sig_d_d;
    logic                   sig_s;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], sig_in};
        sig_s   = sync_q[SYNC_STAGES-1];
        sig_d_d = sig_s;
        rise    = sig_s & ~sig_d_q;
        fall    = ~sig_s & sig_d_q;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            sig_d_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            sig_d_q <= sig_d_d;
        end
    end

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow asynchronous signal in clk_in
// cycles; results are handed to the core via start / valid / ack.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             start,
    input  logic             ack,
    output logic             busy,
    output logic             valid,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             rise;
    logic             fall;

    edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk_in (clk_in),
        .rst_n  (reset),
        .sig_in (sig_in),
        .rise   (rise),
        .fall   (fall)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        high_d   = high_q;
        busy_d   = busy_q;
        valid_d  = valid_q;
        ovf_d    = ovf_q;
        // Counter holds at all-ones rather than wrapping.
        cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ARM;
                    busy_d  = 1'b1;
                    valid_d = 1'b0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                end else if (ack && valid_q) begin
                    valid_d = 1'b0;
                end
            end
            ARM: begin
                if (rise) begin
                    cnt_d   = CNT_ONE;
                    state_d = MEAS_HIGH;
                end
            end
            MEAS_HIGH: begin
                if (fall) begin
                    high_d  = cnt_q;
                    cnt_d   = cnt_inc;
                    state_d = MEAS_LOW;
                end else if (cnt_q == CNT_MAX) begin
                    ovf_d    = 1'b1;
                    period_d = CNT_MAX;
                    high_d   = CNT_MAX;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            MEAS_LOW: begin
                if (rise) begin
                    period_d = cnt_q;
                    state_d  = DONE;
                end else if (cnt_q == CNT_MAX) begin
                    ovf_d    = 1'b1;
                    period_d = CNT_MAX;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            DONE: begin
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            high_q   <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            high_q   <= high_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy      = busy_q;
    assign valid     = valid_q;
    assign period    = period_q;
    assign high_time = high_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: a 16-bit instance for normal measurements
// and a 4-bit instance for counter saturation.
module tb_period_meter;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        sig_in = 1'b0;
    logic        start;
    logic        ack;
    logic        busy;
    logic        valid;
    logic [15:0] period;
    logic [15:0] high_time;
    logic        overflow;

    logic        sig_b;
    logic        start_b;
    logic        ack_b;
    logic        busy_b;
    logic        valid_b;
    logic [3:0]  period_b;
    logic [3:0]  high_b;
    logic        overflow_b;

    int errors = 0;
    int checks = 0;

    // Square-wave source standing in for the clock divider.
    bit wave_on = 1'b0;
    int hi_len  = 3;
    int lo_len  = 3;
    int ph      = 0;

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (!wave_on) begin
            ph     = 0;
            sig_in = 1'b0;
        end else begin
            sig_in = (ph < hi_len);
            ph     = (ph + 1 >= hi_len + lo_len) ? 0 : ph + 1;
        end
    end

    period_meter #(
        .CNT_W(16),
        .SYNC_STAGES(2)
    ) u_dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .sig_in    (sig_in),
        .start     (start),
        .ack       (ack),
        .busy      (busy),
        .valid     (valid),
        .period    (period),
        .high_time (high_time),
        .overflow  (overflow)
    );

    period_meter #(
        .CNT_W(4),
        .SYNC_STAGES(2)
    ) u_dut_b (
        .clk_in    (clk_in),
        .reset     (reset),
        .sig_in    (sig_b),
        .start     (start_b),
        .ack       (ack_b),
        .busy      (busy_b),
        .valid     (valid_b),
        .period    (period_b),
        .high_time (high_b),
        .overflow  (overflow_b)
    );

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        start   = 1'b0;
        ack     = 1'b0;
        sig_b   = 1'b0;
        start_b = 1'b0;
        ack_b   = 1'b0;
        wave_on = 1'b0;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
        checks++;
        if (period !== 16'd0) begin errors++; $display("FAIL reset_period: got %0d want 0", period); end
        checks++;
        if (high_time !== 16'd0) begin errors++; $display("FAIL reset_high: got %0d want 0", high_time); end
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        checks++;
        if (valid_b !== 1'b0 || busy_b !== 1'b0) begin
            errors++; $display("FAIL reset_b: got valid=%b busy=%b want 0/0", valid_b, busy_b);
        end
        reset = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_basic();
        bit ok;
        hi_len  = 3;
        lo_len  = 3;
        wave_on = 1'b1;
        repeat (2) tick();
        pulse_start();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
        wait_valid(60, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_timeout: got no valid want valid within 60 cycles"); end
        checks++;
        if (period !== 16'd6) begin errors++; $display("FAIL basic_period: got %0d want 6", period); end
        checks++;
        if (high_time !== 16'd3) begin errors++; $display("FAIL basic_high: got %0d want 3", high_time); end
        checks++;
        if (overflow !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_flags: got ovf=%b busy=%b want 0/0", overflow, busy);
        end
        repeat (5) tick();
        checks++;
        if (valid !== 1'b1) begin errors++; $display("FAIL basic_hold: got valid=%b want 1", valid); end
        pulse_ack();
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL basic_ack: got valid=%b want 0", valid); end
        checks++;
        if (period !== 16'd6) begin errors++; $display("FAIL basic_period_held: got %0d want 6", period); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        for (int r = 0; r < 4; r++) begin
            pulse_start();
            wait_valid(60, ok);
            checks++;
            if (!ok || period !== 16'd6 || high_time !== 16'd3) begin
                errors++;
                $display("FAIL b2b_round%0d: got ok=%b period=%0d high=%0d want 1/6/3", r, ok, period, high_time);
            end
            pulse_ack();
            tick();
        end
    endtask

    task automatic test_overflow();
        bit found = 1'b0;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        repeat (2) tick();
        sig_b = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (valid_b === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL ovf_timeout: got no valid want valid within 60 cycles"); end
        checks++;
        if (overflow_b !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow_b); end
        checks++;
        if (period_b !== 4'd15) begin errors++; $display("FAIL ovf_period: got %0d want 15", period_b); end
        checks++;
        if (high_b !== 4'd15) begin errors++; $display("FAIL ovf_high: got %0d want 15", high_b); end
        checks++;
        if (busy_b !== 1'b0) begin errors++; $display("FAIL ovf_busy: got %b want 0", busy_b); end
        sig_b = 1'b0;
        ack_b = 1'b1;
        tick();
        ack_b = 1'b0;
    endtask

    task automatic test_high_at_start();
        bit ok;
        wave_on = 1'b0;
        repeat (4) tick();
        hi_len  = 8;
        lo_len  = 2;
        wave_on = 1'b1;
        repeat (5) tick();
        pulse_start();
        wait_valid(80, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL hstart_timeout: got no valid want valid within 80 cycles"); end
        checks++;
        if (period !== 16'd10) begin errors++; $display("FAIL hstart_period: got %0d want 10", period); end
        checks++;
        if (high_time !== 16'd8) begin errors++; $display("FAIL hstart_high: got %0d want 8", high_time); end
        pulse_ack();
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        wave_on = 1'b0;
        repeat (4) tick();
        hi_len = 4;
        lo_len = 20;
        pulse_start();
        repeat (2) tick();
        wave_on = 1'b1;
        repeat (10) tick();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before: got %b want 1", busy); end
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            errors++; $display("FAIL rmid_flags: got busy=%b valid=%b want 0/0", busy, valid);
        end
        checks++;
        if (period !== 16'd0 || high_time !== 16'd0 || overflow !== 1'b0) begin
            errors++; $display("FAIL rmid_fields: got period=%0d high=%0d ovf=%b want 0/0/0", period, high_time, overflow);
        end
        repeat (2) tick();
        reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL rmid_quiet: got valid/busy activity want none until start"); end
        wave_on = 1'b0;
    endtask

    task automatic test_start_ack_together();
        bit ok;
        int first = -1;
        hi_len  = 3;
        lo_len  = 3;
        wave_on = 1'b1;
        tick();
        pulse_start();
        wait_valid(60, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL sa_prep: got no valid want valid within 60 cycles"); end
        wave_on = 1'b0;
        repeat (4) tick();
        start = 1'b1;
        ack   = 1'b1;
        tick();
        start = 1'b0;
        ack   = 1'b0;
        checks++;
        if (valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL sa_together: got valid=%b busy=%b want 0/1", valid, busy);
        end
        // A restart from either extra pulse would push valid out by a full period.
        hi_len  = 3;
        lo_len  = 5;
        wave_on = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (valid === 1'b1 && first < 0) first = i;
            start = (i == 4 || i == 8);
        end
        start = 1'b0;
        checks++;
        if (first < 0 || first > 14) begin
            errors++; $display("FAIL sa_no_restart: got valid at tick %0d want tick <= 14", first);
        end
        checks++;
        if (period !== 16'd8 || high_time !== 16'd3) begin
            errors++; $display("FAIL sa_result: got period=%0d high=%0d want 8/3", period, high_time);
        end
        pulse_ack();
        wave_on = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_overflow();
        test_high_at_start();
        test_reset_mid();
        test_start_ack_together();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end

endmodule
